// File: rtl/delay_n.sv
// Fixed-latency delay line: data_o is data_i delayed by DEPTH clock cycles.
// DEPTH = 0 collapses to a combinational pass-through.
module delay_n #(
  parameter int DWIDTH = 12,
  parameter int DEPTH  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DWIDTH-1:0] data_i,
  output logic [DWIDTH-1:0] data_o
);

  if (DWIDTH < 1) begin : g_bad_width
    $error("delay_n: DWIDTH must be >= 1");
  end

  if (DEPTH < 0) begin : g_bad_depth
    $error("delay_n: DEPTH must be >= 0");
  end else if (DEPTH == 0) begin : g_pass
    // No state at all; clock and reset are deliberately ignored.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign data_o = data_i;
  end else begin : g_pipe
    logic [DEPTH-1:0][DWIDTH-1:0] stage_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        stage_q <= '0;
      end else begin
        stage_q[0] <= data_i;
        for (int k = 1; k < DEPTH; k++) begin
          stage_q[k] <= stage_q[k-1];
        end
      end
    end

    assign data_o = stage_q[DEPTH-1];
  end

endmodule

// File: tb/tb_delay_n.sv
// Directed bench for delay_n covering depths 3, 1, 0 and widths 1, 12, 32.
module tb_delay_n;

  logic        clk;
  logic        rst;
  logic [11:0] d3_in, d3_out;
  logic [11:0] d1_in, d1_out;
  logic [11:0] d0_in, d0_out;
  logic        w1_in, w1_out;
  logic [31:0] w32_in, w32_out;

  int n_cmp;
  int n_err;

  delay_n #(.DWIDTH(12), .DEPTH(3)) u_d3 (
    .clk(clk), .rst(rst), .data_i(d3_in), .data_o(d3_out)
  );
  delay_n #(.DWIDTH(12), .DEPTH(1)) u_d1 (
    .clk(clk), .rst(rst), .data_i(d1_in), .data_o(d1_out)
  );
  delay_n #(.DWIDTH(12), .DEPTH(0)) u_d0 (
    .clk(clk), .rst(rst), .data_i(d0_in), .data_o(d0_out)
  );
  delay_n #(.DWIDTH(1), .DEPTH(3)) u_w1 (
    .clk(clk), .rst(rst), .data_i(w1_in), .data_o(w1_out)
  );
  delay_n #(.DWIDTH(32), .DEPTH(3)) u_w32 (
    .clk(clk), .rst(rst), .data_i(w32_in), .data_o(w32_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1;
    d3_in = '0; d1_in = '0; d0_in = '0; w1_in = 1'b0; w32_in = '0;
    repeat (2) begin
      @(negedge clk);
      n_cmp++;
      if (d3_out !== 12'h000) begin
        n_err++; $display("FAIL reset_d3: got %h expected %h", d3_out, 12'h000);
      end
      n_cmp++;
      if (d1_out !== 12'h000) begin
        n_err++; $display("FAIL reset_d1: got %h expected %h", d1_out, 12'h000);
      end
      n_cmp++;
      if (w32_out !== 32'h0) begin
        n_err++; $display("FAIL reset_w32: got %h expected %h", w32_out, 32'h0);
      end
      n_cmp++;
      if (w1_out !== 1'b0) begin
        n_err++; $display("FAIL reset_w1: got %b expected %b", w1_out, 1'b0);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (d3_out !== 12'h000) begin
        n_err++; $display("FAIL reset_fill[%0d]: got %h expected %h", i, d3_out, 12'h000);
      end
    end
  endtask

  task automatic test_latency();
    logic [11:0] exp;
    @(negedge clk);
    d3_in = 12'hABC;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      d3_in = 12'h000;
      exp = (i == 2) ? 12'hABC : 12'h000;
      n_cmp++;
      if (d3_out !== exp) begin
        n_err++; $display("FAIL latency[%0d]: got %h expected %h", i, d3_out, exp);
      end
    end
  endtask

  task automatic test_random_stream();
    logic [11:0] sb[$];
    logic [11:0] exp;
    logic [11:0] v;
    sb = {12'h000, 12'h000, 12'h000};
    @(negedge clk);
    for (int i = 0; i < 20 + 3 + 2; i++) begin
      exp = sb.pop_front();
      n_cmp++;
      if (d3_out !== exp) begin
        n_err++; $display("FAIL stream[%0d]: got %h expected %h", i, d3_out, exp);
      end
      v = (i < 20) ? 12'($urandom_range(4095, 0)) : 12'h000;
      d3_in = v;
      sb.push_back(v);
      @(negedge clk);
    end
    d3_in = 12'h000;
  endtask

  task automatic test_async_reset();
    logic [11:0] exp;
    @(negedge clk); d3_in = 12'h111;
    @(negedge clk); d3_in = 12'h222;
    @(negedge clk); d3_in = 12'h333;
    @(negedge clk);
    d3_in = 12'h444;
    n_cmp++;
    if (d3_out !== 12'h111) begin
      n_err++; $display("FAIL inflight: got %h expected %h", d3_out, 12'h111);
    end
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if (d3_out !== 12'h000) begin
      n_err++; $display("FAIL async_clear: got %h expected %h", d3_out, 12'h000);
    end
    @(negedge clk);
    n_cmp++;
    if (d3_out !== 12'h000) begin
      n_err++; $display("FAIL held_reset: got %h expected %h", d3_out, 12'h000);
    end
    rst = 1'b0;
    d3_in = 12'h7E1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      d3_in = 12'h000;
      exp = (i == 2) ? 12'h7E1 : 12'h000;
      n_cmp++;
      if (d3_out !== exp) begin
        n_err++; $display("FAIL post_reset[%0d]: got %h expected %h", i, d3_out, exp);
      end
    end
  endtask

  task automatic test_depth1();
    @(negedge clk);
    d1_in = 12'h5A5;
    n_cmp++;
    if (d1_out !== 12'h000) begin
      n_err++; $display("FAIL d1_before: got %h expected %h", d1_out, 12'h000);
    end
    @(negedge clk);
    d1_in = 12'h000;
    n_cmp++;
    if (d1_out !== 12'h5A5) begin
      n_err++; $display("FAIL d1_after: got %h expected %h", d1_out, 12'h5A5);
    end
    @(negedge clk);
    n_cmp++;
    if (d1_out !== 12'h000) begin
      n_err++; $display("FAIL d1_clear: got %h expected %h", d1_out, 12'h000);
    end
  endtask

  task automatic test_depth0();
    logic [11:0] vals[4];
    vals = '{12'h123, 12'hFFF, 12'hA5A, 12'h000};
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      d0_in = vals[i];
      #1;
      n_cmp++;
      if (d0_out !== vals[i]) begin
        n_err++; $display("FAIL d0_pass[%0d]: got %h expected %h", i, d0_out, vals[i]);
      end
    end
    // Reset must not block the pass-through path.
    rst = 1'b1;
    d0_in = 12'h9C3;
    #1;
    n_cmp++;
    if (d0_out !== 12'h9C3) begin
      n_err++; $display("FAIL d0_rst: got %h expected %h", d0_out, 12'h9C3);
    end
    rst = 1'b0;
  endtask

  task automatic test_width();
    logic [31:0] v32[4];
    logic        v1[4];
    logic [31:0] e32;
    logic        e1;
    v32 = '{32'hFFFF_FFFF, 32'hAAAA_AAAA, 32'h5555_5555, 32'h8000_0001};
    v1  = '{1'b1, 1'b0, 1'b1, 1'b1};
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      e32 = (i >= 3 && i < 7) ? v32[i-3] : 32'h0;
      e1  = (i >= 3 && i < 7) ? v1[i-3] : 1'b0;
      n_cmp++;
      if (w32_out !== e32) begin
        n_err++; $display("FAIL w32[%0d]: got %h expected %h", i, w32_out, e32);
      end
      n_cmp++;
      if (w1_out !== e1) begin
        n_err++; $display("FAIL w1[%0d]: got %b expected %b", i, w1_out, e1);
      end
      w32_in = (i < 4) ? v32[i] : 32'h0;
      w1_in  = (i < 4) ? v1[i] : 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    test_reset();
    test_latency();
    test_random_stream();
    test_async_reset();
    test_depth1();
    test_depth0();
    test_width();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
